// File: rtl/cand_vector_gen.sv
// Candidate generator: draws vectors from a Galois LFSR, offers them to the constraint
// checkers over valid/ready, and emits the first passing vector or pulses fail after MAX_TRIES.
module cand_vector_gen #(
  parameter int               VEC_W     = 64,
  parameter logic [VEC_W-1:0] TAPS      = 64'hD800_0000_0000_0000,
  parameter logic [VEC_W-1:0] SEED_RST  = VEC_W'(1),
  parameter int               MAX_TRIES = 1024,
  parameter int               CNT_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [VEC_W-1:0] seed_in,
  input  logic             start,
  output logic             cand_valid,
  input  logic             cand_ready,
  output logic [VEC_W-1:0] cand_vec,
  input  logic             chk_valid,
  input  logic             chk_pass,
  output logic             sol_valid,
  input  logic             sol_ready,
  output logic [VEC_W-1:0] sol_vec,
  output logic             busy,
  output logic             fail,
  output logic [CNT_W-1:0] tries
);

  // state    | meaning
  // IDLE     | waiting for start; seed_load accepted here only
  // GEN      | advance LFSR and latch the new candidate
  // PRESENT  | candidate offered, waiting for cand_ready
  // WAIT_CHK | waiting for the checker verdict
  // EMIT     | solution offered, waiting for sol_ready
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GEN      = 3'd1,
    PRESENT  = 3'd2,
    WAIT_CHK = 3'd3,
    EMIT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TRIES);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] lfsr, lfsr_nxt, lfsr_step;
  logic [VEC_W-1:0] cand_vec_nxt, sol_vec_nxt;
  logic             cand_valid_nxt, sol_valid_nxt, fail_nxt;
  logic [CNT_W-1:0] tries_nxt, tries_inc;

  assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign tries_inc = tries + CNT_W'(1);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lfsr       <= SEED_RST;
      cand_vec   <= '0;
      cand_valid <= 1'b0;
      sol_vec    <= '0;
      sol_valid  <= 1'b0;
      tries      <= '0;
      fail       <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      cand_vec   <= cand_vec_nxt;
      cand_valid <= cand_valid_nxt;
      sol_vec    <= sol_vec_nxt;
      sol_valid  <= sol_valid_nxt;
      tries      <= tries_nxt;
      fail       <= fail_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    lfsr_nxt       = lfsr;
    cand_vec_nxt   = cand_vec;
    cand_valid_nxt = cand_valid;
    sol_vec_nxt    = sol_vec;
    sol_valid_nxt  = sol_valid;
    tries_nxt      = tries;
    fail_nxt       = 1'b0;
    case (state)
      IDLE: begin
        // The seed lands in lfsr this cycle, so a simultaneous start draws from it in GEN.
        if (seed_load) lfsr_nxt = (seed_in == '0) ? VEC_W'(1) : seed_in;
        if (start) begin
          tries_nxt = '0;
          state_nxt = GEN;
        end
      end
      GEN: begin
        lfsr_nxt       = lfsr_step;
        cand_vec_nxt   = lfsr_step;
        cand_valid_nxt = 1'b1;
        state_nxt      = PRESENT;
      end
      PRESENT: begin
        if (cand_ready) begin
          cand_valid_nxt = 1'b0;
          state_nxt      = WAIT_CHK;
        end
      end
      WAIT_CHK: begin
        if (chk_valid) begin
          if (chk_pass) begin
            sol_vec_nxt   = cand_vec;
            sol_valid_nxt = 1'b1;
            state_nxt     = EMIT;
          end else begin
            tries_nxt = tries_inc;
            if (tries_inc == MAX_CNT) begin
              fail_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              state_nxt = GEN;
            end
          end
        end
      end
      EMIT: begin
        if (sol_ready) begin
          sol_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cand_vector_gen.sv
// Directed bench for cand_vector_gen with a reference LFSR predicting every candidate.
module tb_cand_vector_gen;
  localparam int VEC_W = 64;
  localparam logic [VEC_W-1:0] TAPS = 64'hD800_0000_0000_0000;
  localparam int MAX_TRIES = 4;
  localparam int CNT_W = $clog2(MAX_TRIES + 1);

  logic             clk = 1'b0;
  logic             rst_n, seed_load, start, cand_ready, chk_valid, chk_pass, sol_ready;
  logic [VEC_W-1:0] seed_in;
  logic             cand_valid, sol_valid, busy, fail;
  logic [VEC_W-1:0] cand_vec, sol_vec;
  logic [CNT_W-1:0] tries;

  int checks = 0;
  int errors = 0;
  logic [VEC_W-1:0] ref_lfsr;
  logic [VEC_W-1:0] last_pass;

  cand_vector_gen #(.VEC_W(VEC_W), .TAPS(TAPS), .SEED_RST(64'd1), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in), .start(start),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_vec(cand_vec),
    .chk_valid(chk_valid), .chk_pass(chk_pass),
    .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_vec(sol_vec),
    .busy(busy), .fail(fail), .tries(tries)
  );

  always #5 clk = ~clk;

  function automatic logic [VEC_W-1:0] step(input logic [VEC_W-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a candidate, captures it and completes the handshake.
  task automatic get_cand(output logic ok, output logic [VEC_W-1:0] v);
    for (int i = 0; i < 20 && !cand_valid; i++) tick();
    ok = cand_valid;
    v  = cand_vec;
    if (ok) begin
      cand_ready = 1'b1;
      tick();
      cand_ready = 1'b0;
    end
  endtask

  task automatic verdict(input logic p);
    chk_valid = 1'b1;
    chk_pass  = p;
    tick();
    chk_valid = 1'b0;
    chk_pass  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seed_load = 0; seed_in = '0; start = 0; cand_ready = 0;
    chk_valid = 0; chk_pass = 0; sol_ready = 0;
    tick(); tick();
    checks++;
    if ({cand_valid, sol_valid, busy, fail} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got=%b want=0000", {cand_valid, sol_valid, busy, fail});
    end
    checks++;
    if (tries !== '0 || cand_vec !== '0 || sol_vec !== '0) begin
      errors++; $display("FAIL reset_data tries=%0d cand=%h sol=%h want zeros", tries, cand_vec, sol_vec);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_first_pass();
    logic ok; logic [VEC_W-1:0] v;
    seed_in = 64'd1; seed_load = 1'b1; start = 1'b1;
    tick();
    seed_load = 1'b0; start = 1'b0;
    ref_lfsr = step(64'd1);
    get_cand(ok, v);
    checks++;
    if (!ok || v !== 64'hD800_0000_0000_0000) begin
      errors++; $display("FAIL first_cand ok=%b got=%h want=d800000000000000", ok, v);
    end
    verdict(1'b1);
    last_pass = v;
    checks++;
    if (sol_valid !== 1'b1 || sol_vec !== 64'hD800_0000_0000_0000 || tries !== '0) begin
      errors++; $display("FAIL first_sol valid=%b sol=%h tries=%0d want 1/d800000000000000/0", sol_valid, sol_vec, tries);
    end
    sol_ready = 1'b1; tick(); sol_ready = 1'b0;
    checks++;
    if (sol_valid !== 1'b0 || busy !== 1'b0 || sol_vec !== last_pass) begin
      errors++; $display("FAIL first_emit_done valid=%b busy=%b sol=%h want 0/0/%h", sol_valid, busy, sol_vec, last_pass);
    end
  endtask

  task automatic test_seed_zero();
    logic ok; logic [VEC_W-1:0] v;
    seed_in = '0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    pulse_start();
    ref_lfsr = step(64'd1);
    get_cand(ok, v);
    checks++;
    if (!ok || v !== 64'hD800_0000_0000_0000) begin
      errors++; $display("FAIL seed_zero_cand ok=%b got=%h want=d800000000000000", ok, v);
    end
    verdict(1'b1);
    last_pass = v;
    checks++;
    if (sol_valid !== 1'b1 || sol_vec !== last_pass) begin
      errors++; $display("FAIL seed_zero_sol valid=%b sol=%h want 1/%h", sol_valid, sol_vec, last_pass);
    end
    sol_ready = 1'b1; tick(); sol_ready = 1'b0;
  endtask

  task automatic test_max_tries();
    logic ok; logic [VEC_W-1:0] v;
    pulse_start();
    for (int k = 1; k <= MAX_TRIES; k++) begin
      get_cand(ok, v);
      ref_lfsr = step(ref_lfsr);
      checks++;
      if (!ok || v !== ref_lfsr) begin
        errors++; $display("FAIL reject_cand_%0d ok=%b got=%h want=%h", k, ok, v, ref_lfsr);
      end
      verdict(1'b0);
      checks++;
      if (k < MAX_TRIES) begin
        if (tries !== CNT_W'(k) || fail !== 1'b0) begin
          errors++; $display("FAIL reject_tries_%0d tries=%0d fail=%b want %0d/0", k, tries, fail, k);
        end
      end else begin
        if (tries !== 3'd4 || fail !== 1'b1 || busy !== 1'b0) begin
          errors++; $display("FAIL fail_pulse tries=%0d fail=%b busy=%b want 4/1/0", tries, fail, busy);
        end
      end
    end
    tick();
    checks++;
    if (fail !== 1'b0) begin
      errors++; $display("FAIL fail_width fail=%b want 0", fail);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (cand_valid !== 1'b0 || tries !== 3'd4) begin
        errors++; $display("FAIL after_fail valid=%b tries=%0d want 0/4", cand_valid, tries);
      end
    end
  endtask

  task automatic test_spurious();
    logic ok; logic [VEC_W-1:0] v;
    chk_valid = 1'b1; chk_pass = 1'b0;
    tick();
    chk_valid = 1'b0;
    checks++;
    if (tries !== 3'd4 || busy !== 1'b0 || fail !== 1'b0) begin
      errors++; $display("FAIL idle_spurious tries=%0d busy=%b fail=%b want 4/0/0", tries, busy, fail);
    end
    pulse_start();
    tick();
    ref_lfsr = step(ref_lfsr);
    chk_valid = 1'b1; chk_pass = 1'b1; start = 1'b1; seed_load = 1'b1; seed_in = 64'h1234;
    tick();
    chk_valid = 1'b0; chk_pass = 1'b0; start = 1'b0; seed_load = 1'b0;
    checks++;
    if (cand_valid !== 1'b1 || cand_vec !== ref_lfsr || sol_valid !== 1'b0 || tries !== '0) begin
      errors++; $display("FAIL present_spurious valid=%b cand=%h sol_valid=%b tries=%0d want 1/%h/0/0",
                         cand_valid, cand_vec, sol_valid, tries, ref_lfsr);
    end
    get_cand(ok, v);
    verdict(1'b0);
    checks++;
    if (tries !== 3'd1) begin
      errors++; $display("FAIL spurious_tries tries=%0d want 1", tries);
    end
    get_cand(ok, v);
    ref_lfsr = step(ref_lfsr);
    checks++;
    if (!ok || v !== ref_lfsr) begin
      errors++; $display("FAIL busy_seed_ignored ok=%b got=%h want=%h", ok, v, ref_lfsr);
    end
    verdict(1'b1);
    last_pass = v;
    checks++;
    if (sol_valid !== 1'b1 || sol_vec !== last_pass) begin
      errors++; $display("FAIL spurious_sol valid=%b sol=%h want 1/%h", sol_valid, sol_vec, last_pass);
    end
    sol_ready = 1'b1; tick(); sol_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [VEC_W-1:0] exp;
    pulse_start();
    tick();
    ref_lfsr = step(ref_lfsr);
    exp = ref_lfsr;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (cand_valid !== 1'b1 || cand_vec !== exp) begin
        errors++; $display("FAIL cand_hold_%0d valid=%b cand=%h want 1/%h", i, cand_valid, cand_vec, exp);
      end
      tick();
    end
    cand_ready = 1'b1; tick(); cand_ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b1 || sol_valid !== 1'b0 || cand_valid !== 1'b0) begin
      errors++; $display("FAIL wait_chk busy=%b sol_valid=%b cand_valid=%b want 1/0/0", busy, sol_valid, cand_valid);
    end
    verdict(1'b1);
    last_pass = exp;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (sol_valid !== 1'b1 || sol_vec !== last_pass) begin
        errors++; $display("FAIL sol_hold_%0d valid=%b sol=%h want 1/%h", i, sol_valid, sol_vec, last_pass);
      end
      tick();
    end
    sol_ready = 1'b1; tick(); sol_ready = 1'b0;
    checks++;
    if (sol_valid !== 1'b0 || sol_vec !== last_pass || busy !== 1'b0) begin
      errors++; $display("FAIL sol_after valid=%b sol=%h busy=%b want 0/%h/0", sol_valid, sol_vec, busy, last_pass);
    end
  endtask

  task automatic test_reset_mid();
    logic ok; logic [VEC_W-1:0] v;
    pulse_start();
    get_cand(ok, v);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cand_valid, sol_valid, busy, fail} !== 4'b0000 || tries !== '0 || cand_vec !== '0 || sol_vec !== '0) begin
      errors++; $display("FAIL reset_mid flags=%b tries=%0d cand=%h sol=%h want zeros",
                         {cand_valid, sol_valid, busy, fail}, tries, cand_vec, sol_vec);
    end
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    get_cand(ok, v);
    checks++;
    if (!ok || v !== 64'hD800_0000_0000_0000) begin
      errors++; $display("FAIL post_reset_cand ok=%b got=%h want=d800000000000000", ok, v);
    end
    verdict(1'b1);
    checks++;
    if (sol_valid !== 1'b1 || sol_vec !== v) begin
      errors++; $display("FAIL post_reset_sol valid=%b sol=%h want 1/%h", sol_valid, sol_vec, v);
    end
    sol_ready = 1'b1; tick(); sol_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_pass();
    test_seed_zero();
    test_max_tries();
    test_spurious();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
